// File: rtl/haze_pkg.sv
// Shared types and constants for the instruction encoder.
package haze_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_H    = 3'd6,
    FMT_RSVD = 3'd7
  } format_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bundle of the instruction encoder; slave = encoder side.
interface instruction_encoder_if #(
  parameter int COUNT_W = 16
);
  logic               i_Valid;
  logic               o_Ready;
  logic [2:0]         i_Format;
  logic [6:0]         i_Opcode;
  logic [4:0]         i_RD;
  logic [4:0]         i_RS1;
  logic [4:0]         i_RS2;
  logic [2:0]         i_Func3;
  logic [6:0]         i_Func7;
  logic [31:0]        i_Imm;
  logic               o_Valid;
  logic               i_Ready;
  logic [31:0]        o_Instruction;
  logic               o_Error;
  logic [COUNT_W-1:0] o_Count;

  modport master (
    output i_Valid, i_Format, i_Opcode, i_RD, i_RS1, i_RS2, i_Func3, i_Func7, i_Imm, i_Ready,
    input  o_Ready, o_Valid, o_Instruction, o_Error, o_Count
  );

  modport slave (
    input  i_Valid, i_Format, i_Opcode, i_RD, i_RS1, i_RS2, i_Func3, i_Func7, i_Imm, i_Ready,
    output o_Ready, o_Valid, o_Instruction, o_Error, o_Count
  );

endinterface

// File: rtl/instruction_packer.sv
// Combinational RV32I field packer. HAZE_ENCODER_RANGE_CHECK_EN enables immediate range
// checking; without it out-of-range bits are simply truncated and range_err stays 0.
module instruction_packer
  import haze_pkg::*;
(
  input  format_t     fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  always_comb begin
    word = NOP;
    case (fmt)
      FMT_R:    word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I:    word = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S:    word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:    word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:    word = {imm[31:12], rd, opcode};
      FMT_J:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_H:    word = {func7, imm[4:0], rs1, func3, rd, opcode};
      FMT_RSVD: word = NOP;
      default:  word = NOP;
    endcase
  end

`ifdef HAZE_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(imm);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (simm < -2048) || (simm > 2047);
      FMT_B:        range_err = (simm < -4096) || (simm > 4094) || imm[0];
      FMT_J:        range_err = (simm < -1048576) || (simm > 1048574) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'd0);
      FMT_H:        range_err = (imm[31:5] != 27'd0);
      FMT_RSVD:     range_err = 1'b1;
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs a field bundle into a word and queues it in a DEPTH-entry FIFO.
// Range checking is compiled in with HAZE_ENCODER_RANGE_CHECK_EN (see instruction_packer).
module instruction_encoder
  import haze_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input logic                  i_Clock,
  input logic                  i_Reset,
  instruction_encoder_if.slave bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        lvl_q;
  logic [AW:0]        lvl_d;
  logic               ready_q;
  logic               err_q;
  logic [COUNT_W-1:0] count_q;
  logic [31:0]        packed_word;
  logic               range_err;
  logic               accept;
  logic               push;
  logic               pop;

  instruction_packer u_packer (
    .fmt       (format_t'(bus.i_Format)),
    .opcode    (bus.i_Opcode),
    .rd        (bus.i_RD),
    .rs1       (bus.i_RS1),
    .rs2       (bus.i_RS2),
    .func3     (bus.i_Func3),
    .func7     (bus.i_Func7),
    .imm       (bus.i_Imm),
    .word      (packed_word),
    .range_err (range_err)
  );

  // A rejected request still completes its handshake but never reaches the FIFO.
  assign accept = bus.i_Valid && ready_q;
  assign push   = accept && !range_err;
  assign pop    = (lvl_q != '0) && bus.i_Ready;

  always_comb begin
    lvl_d = lvl_q;
    if (push && !pop)
      lvl_d = lvl_q + 1'b1;
    else if (pop && !push)
      lvl_d = lvl_q - 1'b1;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lvl_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      lvl_q   <= lvl_d;
      // Registered from next occupancy so o_Ready has no path from i_Ready.
      ready_q <= (lvl_d != FULL_LVL);
      err_q   <= accept && range_err;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push)
      mem[wr_ptr] <= packed_word;
  end

  assign bus.o_Ready       = ready_q;
  assign bus.o_Valid       = (lvl_q != '0);
  assign bus.o_Instruction = (lvl_q != '0) ? mem[rd_ptr] : 32'd0;
  assign bus.o_Error       = err_q;
  assign bus.o_Count       = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed cases plus randomized traffic
// scored against a queue-based reference model.
module tb_instruction_encoder;
  import haze_pkg::*;

  localparam int DEPTH   = 2;
  localparam int COUNT_W = 16;

  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;

  instruction_encoder_if #(.COUNT_W(COUNT_W)) ifc();

  instruction_encoder #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .bus     (ifc.slave)
  );

  always #5 i_Clock = ~i_Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packing written as shifts and masks on plain integers.
  function automatic bit [31:0] ref_word(input int fmt, input bit [31:0] op, input bit [31:0] rd,
                                         input bit [31:0] rs1, input bit [31:0] rs2,
                                         input bit [31:0] f3, input bit [31:0] f7,
                                         input bit [31:0] imm);
    bit [31:0] base_r;
    base_r = (rs1 << 15) | (f3 << 12) | op;
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | base_r | (rd << 7);
      1: return ((imm & 32'hFFF) << 20) | base_r | (rd << 7);
      2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | base_r | ((imm & 32'h1F) << 7);
      3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | base_r
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      4: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
              | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      6: return (f7 << 25) | ((imm & 32'h1F) << 20) | base_r | (rd << 7);
      default: return 32'h00000013;
    endcase
  endfunction

  function automatic bit ref_reject(input int fmt, input bit [31:0] imm);
`ifdef HAZE_ENCODER_RANGE_CHECK_EN
    int s;
    s = imm;
    case (fmt)
      1, 2: return (s < -2048) || (s > 2047);
      3:    return (s < -4096) || (s > 4094) || (imm[0] == 1'b1);
      5:    return (s < -1048576) || (s > 1048574) || (imm[0] == 1'b1);
      4:    return (imm & 32'hFFF) != 0;
      6:    return (imm >> 5) != 0;
      7:    return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (fmt < 0) && (imm == 32'd0);
`endif
  endfunction

  // Reference model: queue of expected words, push counter, error flag.
  logic [31:0] exp_q[$];
  int          m_count = 0;
  bit          m_err   = 1'b0;
  bit          sb_en   = 1'b0;

  always @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      exp_q.delete();
      m_count = 0;
      m_err   = 1'b0;
    end else begin
      bit acc, pp, rej;
      acc = ifc.i_Valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() != 0) && ifc.i_Ready;
      rej = acc && ref_reject(int'(ifc.i_Format), ifc.i_Imm);
      if (pp) void'(exp_q.pop_front());
      if (acc && !rej) begin
        exp_q.push_back(ref_word(int'(ifc.i_Format), 32'(ifc.i_Opcode), 32'(ifc.i_RD),
                                 32'(ifc.i_RS1), 32'(ifc.i_RS2), 32'(ifc.i_Func3),
                                 32'(ifc.i_Func7), ifc.i_Imm));
        m_count++;
      end
      m_err = rej;
    end
  end

  always @(negedge i_Clock) begin
    if (sb_en && !i_Reset) begin
      check_eq("sb_valid", 32'(ifc.o_Valid), 32'(exp_q.size() != 0));
      check_eq("sb_ready", 32'(ifc.o_Ready), 32'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0)
        check_eq("sb_word", ifc.o_Instruction, exp_q[0]);
      check_eq("sb_count", 32'(ifc.o_Count), m_count & 32'hFFFF);
      check_eq("sb_error", 32'(ifc.o_Error), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle();
    ifc.i_Valid = 1'b0;
  endtask

  task automatic req(input int fmt, input int op, input int rd, input int rs1, input int rs2,
                     input int f3, input int f7, input int imm);
    ifc.i_Valid  = 1'b1;
    ifc.i_Format = 3'(fmt);
    ifc.i_Opcode = 7'(op);
    ifc.i_RD     = 5'(rd);
    ifc.i_RS1    = 5'(rs1);
    ifc.i_RS2    = 5'(rs2);
    ifc.i_Func3  = 3'(f3);
    ifc.i_Func7  = 7'(f7);
    ifc.i_Imm    = 32'(imm);
  endtask

  function automatic int rand_imm();
    case ($urandom % 5)
      0: return int'($urandom_range(10000)) - 5000;
      1: return int'($urandom);
      2: return int'($urandom & 32'hFFFFF000);
      3: return int'($urandom_range(63));
      default: return int'($urandom_range(4194303)) - 2097152;
    endcase
  endfunction

  task automatic random_phase(input int cycles, input int pv, input int pr);
    for (int c = 0; c < cycles; c++) begin
      if (int'($urandom_range(99)) < pv)
        req(int'($urandom_range(7)), int'($urandom_range(127)), int'($urandom_range(31)),
            int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(7)),
            int'($urandom_range(127)), rand_imm());
      else
        idle();
      ifc.i_Ready = (int'($urandom_range(99)) < pr);
      tick();
    end
  endtask

  initial begin
    ifc.i_Ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    tick();
    tick();
    check_eq("rst_valid", 32'(ifc.o_Valid), 32'd0);
    check_eq("rst_error", 32'(ifc.o_Error), 32'd0);
    check_eq("rst_count", 32'(ifc.o_Count), 32'd0);
    check_eq("rst_word", ifc.o_Instruction, 32'd0);
    i_Reset = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ifc.o_Ready), 32'd1);
    sb_en = 1'b1;

    // addi x1, x0, 5
    req(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 5);
    tick();
    idle();
    check_eq("i_word", ifc.o_Instruction, 32'h00500093);
    check_eq("i_count", 32'(ifc.o_Count), 32'd1);
    tick();
    check_eq("i_hold", ifc.o_Instruction, 32'h00500093);
    ifc.i_Ready = 1'b1;
    tick();

    req(FMT_B, OP_BRANCH, 0, 1, 2, 0, 0, -4);
    tick();
    idle();
    check_eq("b_word", ifc.o_Instruction, 32'hFE208EE3);
    tick();

    req(FMT_U, OP_LUI, 5, 0, 0, 0, 0, 32'h12345000);
    tick();
    idle();
    check_eq("u_word", ifc.o_Instruction, 32'h123452B7);
    tick();

    req(FMT_J, OP_JAL, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    check_eq("j_word", ifc.o_Instruction, 32'h0000006F);
    tick();

    // Backpressure: third request must stall on a full FIFO.
    ifc.i_Ready = 1'b0;
    req(FMT_R, OP_REG, 3, 4, 5, 0, 32, 0);
    tick();
    check_eq("bp_ready1", 32'(ifc.o_Ready), 32'd1);
    req(FMT_S, OP_STORE, 0, 2, 7, 2, 0, 12);
    tick();
    check_eq("bp_ready2", 32'(ifc.o_Ready), 32'd0);
    req(FMT_I, OP_IMM, 9, 9, 0, 0, 0, 9);
    tick();
    check_eq("bp_ready3", 32'(ifc.o_Ready), 32'd0);
    check_eq("bp_count", 32'(ifc.o_Count), 32'd6);
    check_eq("bp_head", ifc.o_Instruction, 32'h405201B3);
    idle();
    ifc.i_Ready = 1'b1;
    tick();
    check_eq("bp_ready_pop", 32'(ifc.o_Ready), 32'd1);
    check_eq("bp_second", ifc.o_Instruction, 32'h00712623);
    tick();
    check_eq("bp_empty", 32'(ifc.o_Valid), 32'd0);

    req(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 2048);
    tick();
    idle();
`ifdef HAZE_ENCODER_RANGE_CHECK_EN
    check_eq("rng_error", 32'(ifc.o_Error), 32'd1);
    check_eq("rng_nopush", 32'(ifc.o_Valid), 32'd0);
    check_eq("rng_count", 32'(ifc.o_Count), 32'd6);
    tick();
    check_eq("rng_pulse", 32'(ifc.o_Error), 32'd0);
`else
    check_eq("rng_word", ifc.o_Instruction, 32'h80000093);
    check_eq("rng_count", 32'(ifc.o_Count), 32'd7);
    check_eq("rng_error", 32'(ifc.o_Error), 32'd0);
    tick();
`endif

    // Asynchronous reset with two words queued.
    ifc.i_Ready = 1'b0;
    req(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 1);
    tick();
    req(FMT_I, OP_IMM, 2, 0, 0, 0, 0, 2);
    tick();
    idle();
    check_eq("ar_pre_valid", 32'(ifc.o_Valid), 32'd1);
    #2;
    i_Reset = 1'b1;
    #1;
    check_eq("ar_valid", 32'(ifc.o_Valid), 32'd0);
    check_eq("ar_count", 32'(ifc.o_Count), 32'd0);
    check_eq("ar_word", ifc.o_Instruction, 32'd0);
    check_eq("ar_error", 32'(ifc.o_Error), 32'd0);
    #3;
    i_Reset = 1'b0;
    tick();
    check_eq("ar_ready", 32'(ifc.o_Ready), 32'd1);
    req(FMT_I, OP_IMM, 1, 0, 0, 0, 0, 5);
    tick();
    idle();
    check_eq("ar_first_word", ifc.o_Instruction, 32'h00500093);
    check_eq("ar_first_count", 32'(ifc.o_Count), 32'd1);
    ifc.i_Ready = 1'b1;
    tick();

    random_phase(300, 70, 70);
    random_phase(300, 90, 30);
    random_phase(300, 40, 90);

    idle();
    ifc.i_Ready = 1'b1;
    tick();
    tick();
    tick();
    check_eq("drain_valid", 32'(ifc.o_Valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
